// File: rtl/csa_resolve.sv
//------------------------------------------------------------------------------
// Module      : csa_resolve
// Description : Sequential carry-propagate resolver. It turns a carry-save
//               pair (sum, carry; carry bit i has weight 2^(i+1)) into a
//               plain binary result of WIDTH+2 bits. It resolves CHUNK bits
//               per cycle, so a full-width adder is never needed.
//               Optional macro CSA_RESOLVE_THRU_EN: in DONE, in_ready follows
//               out_ready. A new pair can then be accepted in the same cycle
//               the result is taken, which skips IDLE.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csa_resolve #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] res
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int BW   = $clog2(WIDTH + 2);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] b;
  logic [IDXW-1:0]  idx;
  logic             c;
  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [1:0]       top_sum;
  logic             accept;
  logic             last_chunk;

  assign accept     = in_valid & in_ready;
  assign last_chunk = (idx == LAST_IDX);
  assign base       = BW'(int'(idx) * CHUNK);
  assign a_chunk    = a[base +: CHUNK];
  assign b_chunk    = b[base +: CHUNK];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c};
  // The top two bits take the carry out of the last chunk in the same cycle.
  // The maximum is 0 + 1 + 1, so two bits cannot overflow.
  assign top_sum    = a[WIDTH+1:WIDTH] + b[WIDTH+1:WIDTH] + {1'b0, chunk_sum[CHUNK]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) state_nxt = S_ADD;
      end
      S_ADD: begin
        if (last_chunk) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
`ifdef CSA_RESOLVE_THRU_EN
          state_nxt = in_valid ? S_ADD : S_IDLE;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    out_valid = (state == S_DONE);
`ifdef CSA_RESOLVE_THRU_EN
    in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
`else
    in_ready  = (state == S_IDLE);
`endif
  end

  // Operand capture and chunk-by-chunk resolution of the result
  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      idx <= '0;
      c   <= 1'b0;
      res <= '0;
    end else if (accept) begin
      a   <= {2'b00, in_sum};
      b   <= {1'b0, in_carry, 1'b0};
      idx <= '0;
      c   <= 1'b0;
    end else if (state == S_ADD) begin
      res[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
      c                  <= chunk_sum[CHUNK];
      idx                <= idx + IDXW'(1);
      if (last_chunk) begin
        res[WIDTH+1:WIDTH] <= top_sum;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csa_resolve.sv
//------------------------------------------------------------------------------
// Module      : tb_csa_resolve
// Description : Scoreboard bench for csa_resolve (WIDTH=32, CHUNK=8). Stimulus
//               pushes the expected results. A monitor checks every accepted
//               result, the accept-to-valid latency and the spacing of results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_csa_resolve;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
`ifdef CSA_RESOLVE_THRU_EN
  localparam int PERIOD = N + 1;
`else
  localparam int PERIOD = N + 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_sum;
  logic [WIDTH-1:0]  in_carry;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH+1:0]  res;

  int                errors = 0;
  int                checks = 0;
  int                cyc    = 0;
  int                last_rise = 0;
  int                prev_rise = 0;
  logic [WIDTH+1:0]  exp_q[$];
  int                acc_q[$];

  csa_resolve #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [WIDTH+1:0] act, input logic [WIDTH+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on each out_valid rise, result value on each handshake
  initial begin : monitor
    logic prev_ov;
    logic [WIDTH+1:0] e;
    int a0;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          prev_rise = last_rise;
          last_rise = cyc;
          if (acc_q.size() == 0) begin
            chk("latency_no_accept", 1, 0);
          end else begin
            a0 = acc_q.pop_front();
            chk("latency", (WIDTH+2)'(cyc - a0), (WIDTH+2)'(N));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", res, '1);
          end else begin
            e = exp_q.pop_front();
            chk("res", res, e);
          end
        end
        if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        prev_ov = out_valid;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] cr, input logic [WIDTH+1:0] e);
    int n;
    in_sum   = s;
    in_carry = cr;
    in_valid = 1'b1;
    exp_q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {33'd0, in_ready}, 1);
    chk("rst_out_valid", {33'd0, out_valid}, 0);
    chk("rst_res", res, 0);
    @(posedge clk);
    #1;

    // Basic pairs, chunk boundary carry, top-bit maximum
    send(32'h00000001, 32'h00000001, 34'h3);
    wait_empty();
    send(32'h000000FF, 32'h00000001, 34'h101);
    wait_empty();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 34'h2FFFFFFFD);
    wait_empty();
    send(32'h80000000, 32'h80000000, 34'h180000000);
    wait_empty();

    // Consumer stalls for 5 cycles in DONE while the producer pulses in_valid
    out_ready = 1'b0;
    send(32'h12345678, 32'h0F0F0F0F, 34'h30527496);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("hold_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {33'd0, out_valid}, 1);
      chk("hold_res", res, 34'h30527496);
      chk("hold_in_ready", {33'd0, in_ready}, 0);
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_sum   = 32'hDEADBEEF;
      in_carry = 32'h01234567;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty();

    // Reset during the second ADD cycle discards the operation
    send(32'h00000005, 32'h00000005, 34'hF);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {33'd0, in_ready}, 1);
    chk("midrst_out_valid", {33'd0, out_valid}, 0);
    chk("midrst_res", res, 0);
    @(posedge clk);
    #1;
    send(32'h00000010, 32'h00000008, 34'h20);
    wait_empty();

    // Back-to-back pairs with in_valid held and out_ready high
    send(32'h00000001, 32'h00000001, 34'h3);
    send(32'h00000002, 32'h00000002, 34'h6);
    wait_empty();
    chk("b2b_period", (WIDTH+2)'(last_rise - prev_rise), (WIDTH+2)'(PERIOD));

    repeat (8) @(posedge clk);
    chk("no_stray_accepts", (WIDTH+2)'(acc_q.size()), 0);
    chk("scoreboard_empty", (WIDTH+2)'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
